// File: rtl/aes_inv_cipher_iter_if.sv
// aes_inv_cipher_iter_if
//   Handshake and data bus of the iterative AES-128 inverse cipher.
//   slave  : the cipher side (accepts ct, requests round keys, presents pt)
//   master : the environment side (ciphertext producer, key store, consumer)
//   Signals:
//     in_valid/in_ready   ciphertext handshake
//     ct                  ciphertext block, row-major packing
//     rk_idx/rk           round-key request index and the key returned in the same cycle
//     out_valid/out_ready plaintext handshake
//     pt                  plaintext block, row-major packing
interface aes_inv_cipher_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ct;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] pt;

    modport master (
        output in_valid, ct, rk, out_ready,
        input  in_ready, rk_idx, out_valid, pt
    );

    modport slave (
        input  in_valid, ct, rk, out_ready,
        output in_ready, rk_idx, out_valid, pt
    );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter
//   Iterative AES-128 inverse cipher: one round per clock, 10 rounds per block.
//   State packing (ct, rk, pt): row r at [127-32r -: 32], column c at [127-32r-8c -: 8].
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    aes_inv_cipher_iter_if.slave (in_valid/in_ready/ct, rk_idx/rk,
//            out_valid/out_ready/pt)
//   Optional feature, macro AES_DEC_SCRUB_EN: clears the state register on the
//   output handshake and forces pt to 0 whenever out_valid is low.
module aes_inv_cipher_iter (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_inv_cipher_iter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_q, state_d;
    logic [127:0] sub_rk;

    // GF(2^8) multiply, reduction polynomial 0x11B.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse S-box: inverse affine transform, then multiplicative inverse
    // computed as y^254 (maps 0 to 0 as required).
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        logic [7:0] sq;
        logic [7:0] acc;
        for (int unsigned i = 0; i < 8; i++) begin
            y[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8];
        end
        y   = y ^ 8'h05;
        sq  = y;
        acc = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Row r rotates right by r bytes.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                o[127 - 32*r - 8*c -: 8] = s[127 - 32*r - 8*((c + 4 - r) % 4) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127 - 8*c -: 8];
            a1 = s[95  - 8*c -: 8];
            a2 = s[63  - 8*c -: 8];
            a3 = s[31  - 8*c -: 8];
            o[127 - 8*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[95  - 8*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[63  - 8*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[31  - 8*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    always_comb begin
        sub_rk = inv_sub_bytes(inv_shift_rows(state_q)) ^ bus.rk;
    end

    always_comb begin
        fsm_d         = fsm_q;
        rnd_d         = rnd_q;
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.rk_idx    = rnd_q;
        case (fsm_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                bus.rk_idx   = 4'd10;
                if (bus.in_valid) begin
                    state_d = bus.ct ^ bus.rk;
                    rnd_d   = 4'd9;
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rnd_q == 4'd0) begin
                    state_d = sub_rk;
                    fsm_d   = ST_DONE;
                end else begin
                    state_d = inv_mix_columns(sub_rk);
                    rnd_d   = rnd_q - 4'd1;
                end
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    fsm_d = ST_IDLE;
`ifdef AES_DEC_SCRUB_EN
                    state_d = '0;
`endif
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

`ifdef AES_DEC_SCRUB_EN
    assign bus.pt = (fsm_q == ST_DONE) ? state_q : '0;
`else
    assign bus.pt = state_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            rnd_q   <= '0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb_aes_inv_cipher_iter
//   Directed bench for aes_inv_cipher_iter. A byte-level FIPS-197 model
//   (key expansion + InvCipher in FIPS byte order) supplies round keys and
//   expected plaintexts; a per-cycle compare process tracks the handshake
//   timeline and checks in_ready/out_valid/rk_idx/pt every cycle.
module tb_aes_inv_cipher_iter;

    logic clk;
    logic rst_n;
    aes_inv_cipher_iter_if bus ();

    aes_inv_cipher_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sbox_t  [256];
    logic [7:0]   isbox_t [256];
    logic [127:0] rk_fips [11];
    logic [127:0] rk_rm   [11];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] a;
        p = 8'h00;
        a = a_in;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // Forward S-box from brute-force field inverse + affine map; inverse S-box by table inversion.
    task automatic init_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox_t[x]  = s;
            isbox_t[s] = 8'(x);
        end
    endtask

    // FIPS byte b[r+4c] -> row r, column c of the row-major packing.
    function automatic logic [127:0] to_rm(input logic [127:0] f);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 32*r - 8*c -: 8] = f[127 - 8*(r + 4*c) -: 8];
        return o;
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            rk_fips[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            rk_rm[r]   = to_rm(rk_fips[r]);
        end
    endtask

    function automatic logic [127:0] model_dec(input logic [127:0] ctv);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = ctv[127 - 8*i -: 8] ^ rk_fips[10][127 - 8*i -: 8];
        for (int rd = 9; rd >= 0; rd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r + 4*((c + r) % 4)] = s[r + 4*c];
            for (int i = 0; i < 16; i++) s[i] = isbox_t[t[i]] ^ rk_fips[rd][127 - 8*i -: 8];
            if (rd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                    s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                    s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                    s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
                end
            end
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    // Key store: combinational lookup by the requested index.
    always_comb begin
        bus.rk = '0;
        if (bus.rk_idx <= 4'd10) bus.rk = rk_rm[bus.rk_idx];
    end

    // Per-cycle checker. cyc: 0 = idle, 1..10 = rounds 9..0 in flight, 11 = result presented.
    bit           trk_on  = 1'b0;
    int           cyc     = 0;
    logic [127:0] exp_pt  = '0;
    logic [127:0] idle_pt = '0;

    always @(negedge clk) begin
        if (trk_on) begin
            chk("in_ready",  128'(bus.in_ready),  128'(cyc == 0));
            chk("out_valid", 128'(bus.out_valid), 128'(cyc == 11));
            if (cyc == 0) begin
                chk("rk_idx_idle", 128'(bus.rk_idx), 128'd10);
                chk("pt_idle", bus.pt, idle_pt);
            end else if (cyc <= 10) begin
                chk("rk_idx_run", 128'(bus.rk_idx), 128'(10 - cyc));
`ifdef AES_DEC_SCRUB_EN
                chk("pt_run_scrubbed", bus.pt, '0);
`endif
            end else begin
                chk("pt_done", bus.pt, exp_pt);
            end
        end
        if (!rst_n) begin
            trk_on  = 1'b1;
            cyc     = 0;
            idle_pt = '0;
        end else if (trk_on) begin
            if (cyc == 0) begin
                if (bus.in_valid) begin
                    cyc    = 1;
                    exp_pt = to_rm(model_dec(to_fips(bus.ct)));
                end
            end else if (cyc < 11) begin
                cyc++;
            end else if (bus.out_ready) begin
                cyc = 0;
`ifdef AES_DEC_SCRUB_EN
                idle_pt = '0;
`else
                idle_pt = exp_pt;
`endif
            end
        end
    end

    function automatic logic [127:0] to_fips(input logic [127:0] rm);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 8*(r + 4*c) -: 8] = rm[127 - 32*r - 8*c -: 8];
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({name, "_out_valid_timeout"}, 128'(ok), 128'd1);
    endtask

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_2   = 128'h0123456789abcdeffedcba9876543210;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] v;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.ct        = '0;
        bus.out_ready = 1'b1;
        init_tables();

        // Model pins against published FIPS-197 values.
        v = 128'(sbox_t[8'h00]);  chk("model_sbox_00", v, 128'h63);
        v = 128'(sbox_t[8'h53]);  chk("model_sbox_53", v, 128'hed);
        v = 128'(isbox_t[8'h63]); chk("model_isbox_63", v, 128'h00);
        expand(KEY_B);
        chk("model_rk10_b", rk_fips[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("model_dec_b", model_dec(CT_B), PT_B);
        expand(KEY_C1);
        chk("model_rk10_c1", rk_fips[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("model_dec_c1", model_dec(CT_C1), PT_C1);

        // Reset with random inputs for two edges.
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.ct        = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
        end
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("reset_in_ready",  128'(bus.in_ready),  128'd1);
        chk("reset_out_valid", 128'(bus.out_valid), 128'd0);
        chk("reset_pt",        bus.pt,              '0);
        chk("reset_rk_idx",    128'(bus.rk_idx),    128'd10);
        tick();

        // FIPS-197 C.1
        bus.ct = to_rm(CT_C1);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_out("c1");
        chk("c1_pt", bus.pt, to_rm(PT_C1));
        tick();
`ifdef AES_DEC_SCRUB_EN
        chk("c1_pt_after_handshake", bus.pt, '0);
`else
        chk("c1_pt_after_handshake", bus.pt, to_rm(PT_C1));
`endif

        // FIPS-197 Appendix B
        expand(KEY_B);
        bus.ct = to_rm(CT_B);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_out("b");
        chk("b_pt", bus.pt, to_rm(PT_B));
        tick();

        // Backpressure with a second ct offered throughout.
        bus.ct = to_rm(CT_B);
        bus.in_valid = 1'b1;
        tick();
        bus.ct = to_rm(CT_2);
        bus.out_ready = 1'b0;
        wait_out("bp");
        for (int i = 0; i < 5; i++) begin
            chk("bp_pt_hold",  bus.pt, to_rm(PT_B));
            chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_in_ready_after", 128'(bus.in_ready), 128'd1);
        tick();
        bus.in_valid = 1'b0;
        wait_out("bp2");
        chk("bp_second_pt", bus.pt, to_rm(model_dec(CT_2)));
        tick();

        // Reset while round 5 is in flight.
        bus.ct = to_rm(CT_B);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rk_idx == 4'd5) break;
            tick();
        end
        chk("abort_reached_rnd5", 128'(bus.rk_idx), 128'd5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_in_ready",  128'(bus.in_ready),  128'd1);
        chk("abort_out_valid", 128'(bus.out_valid), 128'd0);
        chk("abort_rk_idx",    128'(bus.rk_idx),    128'd10);
        for (int i = 0; i < 15; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_iter.md
# aes_inv_cipher_iter

Iterative AES-128 inverse cipher that decrypts one 128-bit block in 10 round-cycles, one round per clock. It is the decrypt-side counterpart of the encrypt datapath and applies InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns on the same row-major state packing. It sits between a ciphertext producer and a plaintext consumer, with a valid/ready handshake on each side. Round keys come combinationally from an external key-schedule store, indexed by this block.

## Interface
- No parameters: AES-128 only, Nr = 10 fixed.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  ct is valid.
- in_ready  out  1  block is idle and can accept ct.
- ct  in  128  ciphertext block, row-major packing (below).
- rk_idx  out  4  index of the round key needed this cycle (0..10).
- rk  in  128  round key rk_idx, row-major packing; combinational, same cycle.
- out_valid  out  1  pt is valid.
- out_ready  in  1  consumer accepts pt.
- pt  out  128  plaintext block, row-major packing.

## Operation
- Packing for ct, rk and pt: row r (0..3) at bits [127-32r -: 32]; column c (0..3) within the row at bits [127-32r-8c -: 8]. FIPS-197 byte sequence b0..b15 maps to row r, column c = b[r+4c].
- InvShiftRows: row r rotates right by r bytes. Row 1 {a,b,c,d} becomes {d,a,b,c}. Row 2 swaps 16-bit halves. Row 3 {a,b,c,d} becomes {b,c,d,a}.
- InvSubBytes: inverse S-box on all 16 bytes. It is combinational logic (table or GF(2^8) inverse plus inverse affine transform) inside this block.
- InvMixColumns: per column, matrix {0e,0b,0d,09} over GF(2^8) with reduction polynomial 0x11B.
- FSM states:
  - IDLE: in_ready=1, rk_idx=10. On in_valid, load state ← ct ^ rk, set rnd ← 9, go to RUN.
  - RUN: rk_idx=rnd.
    - For rnd 9..1: state ← InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk), then rnd decrements.
    - For rnd 0: state ← InvSubBytes(InvShiftRows(state)) ^ rk, go to DONE.
  - DONE: out_valid=1, pt=state. When out_ready=1, go to IDLE.
- in_ready is high only in IDLE. A new block is never accepted in DONE, even in the same cycle that out_ready is high.
- in_valid and ct are ignored outside IDLE.
- rk_idx and in_ready/out_valid are decoded combinationally from the FSM state and rnd.

## Timing
- Reset values, after the first edge with rst_n=0: FSM=IDLE, rnd=0, state=0. Outputs: in_ready=1, out_valid=0, pt=0, rk_idx=10.
- Accept edge E0: in_valid & in_ready.
- Edges E1..E10 perform rounds 9..0.
- out_valid rises in the cycle after E10, i.e. 10 cycles after E0.
- Output hold: while out_valid=1 and out_ready=0, pt and out_valid stay stable.
- Throughput with out_ready tied high: one block per 12 cycles (E0, 10 RUN edges, DONE handshake edge). in_ready returns the cycle after the DONE handshake.
- Reset mid-operation, in RUN or DONE with rst_n=0 at an edge:
  - The in-flight block is discarded.
  - All reset values apply on the next cycle.
  - No partial pt is presented.
- rk must be valid for the rk_idx driven in the same cycle. The block places no registered stage on rk.

## Configuration
- Macro: AES_DEC_SCRUB_EN.
- Defined:
  - On the DONE output-handshake edge, the state register is cleared to 0.
  - pt is forced to 0 whenever out_valid=0, so plaintext never lingers on the port.
- Undefined:
  - state is not cleared.
  - pt continues to show the last result (or intermediate round state while in RUN) when out_valid=0.
- Handshake timing and latency are identical in both builds.

## Test plan
- Reset: drive rst_n=0 for 2 edges with random inputs → in_ready=1, out_valid=0, pt=0, rk_idx=10.
- FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f (bench-side key schedule driving rk from rk_idx), ct 69c4e0d86a7b0430d8cdb78070b4c55a transposed to row-major.
  - Required: out_valid exactly 10 cycles after E0; rk_idx sequence 10,9,…,0; pt = 00112233445566778899aabbccddeeff, transposed.
- FIPS-197 Appendix B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32.
  - Required: pt = 3243f6a8885a308d313198a2e0370734.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid rises, with in_valid=1 and a different ct throughout.
  - Required: pt stable, in_ready=0, second ct not accepted. After out_ready=1, in_ready=1 next cycle and the second block decrypts correctly.
- Reset during RUN: assert rst_n=0 at round rnd=5 → next cycle FSM in IDLE, out_valid=0, rk_idx=10; no output for the aborted block.
- Scrub feature:
  - AES_DEC_SCRUB_EN defined: after the output handshake, pt=0 on the following cycle.
  - Undefined: pt still shows the last plaintext in IDLE.
